// File: rtl/sm_pkg.sv
// Shared definitions for the sequencer and its receive-side monitor:
// symbol codes carried on the y stream and the monitor's state encoding.
package sm_pkg;

    localparam int STATE_WIDTH = 2;

    typedef logic [STATE_WIDTH-1:0] sym_t;

    // Symbol codes, shared with the sequencer
    localparam sym_t ST0 = 2'd0;
    localparam sym_t ST1 = 2'd1;
    localparam sym_t ST2 = 2'd2;
    localparam sym_t ST3 = 2'd3;

    // Monitor state: HUNT = not synchronised, Ek = last accepted symbol was k
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        E0   = 3'd1,
        E1   = 3'd2,
        E2   = 3'd3,
        E3   = 3'd4
    } mon_state_t;

    // Monitor state reached after accepting symbol y
    function automatic mon_state_t sym_to_state(input sym_t y);
        case (y)
            ST0:     return E0;
            ST1:     return E1;
            ST2:     return E2;
            default: return E3;
        endcase
    endfunction

endpackage

// File: rtl/sm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sm_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear on clr or reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sm_seq_monitor.sv
// Receive-side checker for the 4-state sequencer symbol stream y.
// Follows the sequencer through 0->1->{2->3 | 3}->0, recovers the ST1 control
// decision, reports closed frames and illegal transitions, and keeps counters.
module sm_seq_monitor
    import sm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_y,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             ctrl_valid,
    output logic             ctrl_bit,
    output logic             frame_done,
    output logic [2:0]       frame_len,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    mon_state_t state, state_nxt;
    logic [2:0] len, len_nxt;
    logic       locked_nxt;
    logic       ctrl_bit_nxt;
    logic       ctrl_ev;
    logic       frame_ev;
    logic       err_ev;
    logic       legal;

    // Next-state and event decode for one accepted symbol
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        len_nxt      = len;
        locked_nxt   = locked;
        ctrl_bit_nxt = ctrl_bit;
        ctrl_ev      = 1'b0;
        frame_ev     = 1'b0;
        err_ev       = 1'b0;
        legal        = 1'b0;

        if (in_valid) begin
            if (state == HUNT) begin
                // Only a frame start synchronises; anything else is silently skipped
                if (in_y == ST0) begin
                    state_nxt  = E0;
                    locked_nxt = 1'b1;
                    len_nxt    = 3'd1;
                end
            end else begin
                case (state)
                    E0:      legal = (in_y == ST1);
                    E1:      legal = (in_y == ST2) || (in_y == ST3);
                    E2:      legal = (in_y == ST3);
                    E3:      legal = (in_y == ST0);
                    default: legal = 1'b0;
                endcase

                if (legal) begin
                    state_nxt = sym_to_state(in_y);
                    len_nxt   = len + 3'd1;
                    if (state == E1) begin
                        ctrl_ev      = 1'b1;
                        ctrl_bit_nxt = (in_y == ST3);
                    end
                    if (state == E3) begin
                        // Closing symbol is also the first symbol of the next frame
                        frame_ev = 1'b1;
                        len_nxt  = 3'd1;
                    end
                end else begin
                    err_ev = 1'b1;
                    if (in_y == ST0) begin
                        // A 0 is always a valid frame start: resync without losing lock
                        state_nxt = E0;
                        len_nxt   = 3'd1;
                    end else begin
                        state_nxt  = HUNT;
                        locked_nxt = 1'b0;
                    end
                end
            end
        end
    end

    // Register FSM state, pulse outputs, sticky outputs and the frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            len        <= 3'd0;
            locked     <= 1'b0;
            ctrl_valid <= 1'b0;
            ctrl_bit   <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= 3'd0;
            err        <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            locked     <= locked_nxt;
            ctrl_valid <= ctrl_ev;
            ctrl_bit   <= ctrl_bit_nxt;
            frame_done <= frame_ev;
            err        <= err_ev;
            if (frame_ev) begin
                frame_len <= len;
            end
            if (clr_cnt) begin
                frame_cnt <= '0;
            end else if (frame_ev) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    sm_sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_ev),
        .clr   (clr_cnt),
        .count (err_cnt)
    );

endmodule
